// File: rtl/matrix_scan_controller_if.sv
// Signal bundle between the LED matrix scan controller and its image selector / matrix drivers.
// The controller itself takes the slave view.
interface matrix_scan_controller_if;
    logic [2:0] state;
    logic [6:0] column_4;
    logic [6:0] column_3;
    logic [6:0] column_2;
    logic [6:0] column_1;
    logic [6:0] column_0;
    logic [2:0] selected_state;
    logic [4:0] columns;
    logic [6:0] rows;
    logic       frame_done;

    modport slave (
        input  state, column_4, column_3, column_2, column_1, column_0,
        output selected_state, columns, rows, frame_done
    );

    modport master (
        output state, column_4, column_3, column_2, column_1, column_0,
        input  selected_state, columns, rows, frame_done
    );
endinterface

// File: rtl/matrix_scan_controller.sv
// Multiplexed 5x7 LED matrix scanner: column dwell prescaler, frame-latched image code,
// a blank cycle between columns, and a frame-counted blink for the error image.
module matrix_scan_controller #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                    clock,
    input  logic                    reset,
    matrix_scan_controller_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    CODE_ERROR = 3'b100;
    localparam logic [2:0]    COL_FIRST  = 3'd4;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]    index_q, index_d;
    logic [2:0]    selected_state_q, selected_state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          frame_done_q, frame_done_d;

    logic          pre_wrap;
    logic          frame_wrap;
    logic [6:0]    row_pat;
    logic [4:0]    columns_o;
    logic [6:0]    rows_o;

    always_comb begin
        pre_wrap         = (prescaler_q == PRE_LAST);
        frame_wrap       = pre_wrap && (index_q == 3'd0);
        prescaler_d      = pre_wrap ? '0 : prescaler_q + 1'b1;
        index_d          = index_q;
        selected_state_d = selected_state_q;
        frame_cnt_d      = frame_cnt_q;
        blink_phase_d    = blink_phase_q;
        frame_done_d     = frame_wrap;

        if (pre_wrap) begin
            index_d = (index_q == 3'd0) ? COL_FIRST : index_q - 3'd1;
        end

        if (frame_wrap) begin
            selected_state_d = bus.state;
            // The blink cadence only runs across consecutive error frames; entering or
            // leaving the error image restarts it in the visible phase.
            if ((bus.state != CODE_ERROR) || (selected_state_q != CODE_ERROR)) begin
                frame_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler_q      <= '0;
            index_q          <= COL_FIRST;
            selected_state_q <= 3'b000;
            frame_cnt_q      <= '0;
            blink_phase_q    <= 1'b0;
            frame_done_q     <= 1'b0;
        end else begin
            prescaler_q      <= prescaler_d;
            index_q          <= index_d;
            selected_state_q <= selected_state_d;
            frame_cnt_q      <= frame_cnt_d;
            blink_phase_q    <= blink_phase_d;
            frame_done_q     <= frame_done_d;
        end
    end

    always_comb begin
        case (index_q)
            3'd4:    row_pat = bus.column_4;
            3'd3:    row_pat = bus.column_3;
            3'd2:    row_pat = bus.column_2;
            3'd1:    row_pat = bus.column_1;
            3'd0:    row_pat = bus.column_0;
            default: row_pat = 7'h7F;
        endcase

        // Prescaler slot 0 is kept dark so the previous column's rows never ghost into the next.
        columns_o = 5'b00000;
        rows_o    = 7'h7F;
        if (prescaler_q != '0) begin
            columns_o = 5'b00001 << index_q;
            if (!((selected_state_q == CODE_ERROR) && blink_phase_q)) begin
                rows_o = row_pat;
            end
        end
    end

    assign bus.columns        = columns_o;
    assign bus.rows           = rows_o;
    assign bus.selected_state = selected_state_q;
    assign bus.frame_done     = frame_done_q;
endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with SCAN_DIV=4, BLINK_FRAMES=2.
// Cycle c counts clock periods after reset release; outputs are sampled on the falling edge.
module tb_matrix_scan_controller;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    matrix_scan_controller_if bus();

    matrix_scan_controller #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [6:0] pat [5];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reset held across a rising edge with the given request code, then released just after an edge.
    task automatic reset_and_release(input logic [2:0] st);
        reset     = 1'b1;
        bus.state = st;
        @(posedge clock);
        @(negedge clock);
        check_eq("rst_columns", 32'(bus.columns), 32'h00);
        check_eq("rst_rows", 32'(bus.rows), 32'h7F);
        check_eq("rst_sel", 32'(bus.selected_state), 32'h0);
        check_eq("rst_frame_done", 32'(bus.frame_done), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Expected column position follows from elapsed time alone: 4 slots per column, 5 columns per frame.
    task automatic cyc(input int c, input logic [2:0] esel, input logic erow_blank, input logic efd);
        int p;
        int idx;
        logic [4:0] ecol;
        logic [6:0] erow;
        @(negedge clock);
        p   = c % SCAN_DIV;
        idx = 4 - ((c / SCAN_DIV) % 5);
        ecol = (p == 0) ? 5'b00000 : (5'b00001 << idx);
        erow = ((p == 0) || erow_blank) ? 7'h7F : pat[idx];
        check_eq($sformatf("columns@%0d", c), 32'(bus.columns), 32'(ecol));
        check_eq($sformatf("rows@%0d", c), 32'(bus.rows), 32'(erow));
        check_eq($sformatf("sel@%0d", c), 32'(bus.selected_state), 32'(esel));
        check_eq($sformatf("frame_done@%0d", c), 32'(bus.frame_done), 32'(efd));
    endtask

    initial begin
        pat[4] = 7'b0101010;
        pat[3] = 7'b1100110;
        pat[2] = 7'b0001111;
        pat[1] = 7'b1110000;
        pat[0] = 7'b1010101;
        bus.column_4 = pat[4];
        bus.column_3 = pat[3];
        bus.column_2 = pat[2];
        bus.column_1 = pat[1];
        bus.column_0 = pat[0];
        bus.state    = 3'b000;

        // Basic scan, frame_done timing and mid-frame request change.
        reset_and_release(3'b000);
        for (int c = 0; c <= 24; c++) begin
            cyc(c, (c < 20) ? 3'b000 : 3'b001, 1'b0, c == 20);
            if (c == 7) bus.state = 3'b001;
        end

        // Error image from reset: two visible frames, two dark frames, then visible again.
        reset_and_release(3'b100);
        for (int c = 0; c <= 104; c++) begin
            cyc(c, (c < 20) ? 3'b000 : 3'b100, (c >= 60) && (c < 100), (c > 0) && (c % 20 == 0));
        end

        // Leave error while dark, then re-enter: blink restarts in the visible phase.
        reset_and_release(3'b100);
        for (int c = 0; c <= 145; c++) begin
            logic [2:0] es;
            es = (c < 20) ? 3'b000 : (c < 80) ? 3'b100 : (c < 100) ? 3'b001 : 3'b100;
            cyc(c, es, ((c >= 60) && (c < 80)) || (c >= 140), (c > 0) && (c % 20 == 0));
            if (c == 65) bus.state = 3'b001;
            if (c == 85) bus.state = 3'b100;
        end

        // Asynchronous reset mid-frame while column 2 is lit.
        reset_and_release(3'b001);
        for (int c = 0; c <= 30; c++) begin
            cyc(c, (c < 20) ? 3'b000 : 3'b001, 1'b0, c == 20);
        end
        #1 reset = 1'b1;
        #1;
        check_eq("async_columns", 32'(bus.columns), 32'h00);
        check_eq("async_rows", 32'(bus.rows), 32'h7F);
        check_eq("async_sel", 32'(bus.selected_state), 32'h0);
        check_eq("async_frame_done", 32'(bus.frame_done), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int c = 0; c <= 21; c++) begin
            cyc(c, (c < 20) ? 3'b000 : 3'b001, 1'b0, c == 20);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
